// File: rtl/i2c_target.sv
// I2C target exposing NUMBER_OF_REGISTERS 8-bit registers at DEVICE_ADDRESS, clocked by an
// oversampling system clock. SDA is open-drain; the state is mirrored on debug_state.
module i2c_target #(
   parameter logic [6:0] DEVICE_ADDRESS      = 7'h11,
   parameter int         NUMBER_OF_REGISTERS = 16,
   parameter int         INDEX_WIDTH         = $clog2(NUMBER_OF_REGISTERS)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   external_serial_clock,
   inout  wire                    external_serial_data,
   output logic                   busy,
   output logic                   write_valid,
   output logic [INDEX_WIDTH-1:0] write_register_address,
   output logic [7:0]             write_data,
   input  logic [INDEX_WIDTH-1:0] register_index,
   output logic [7:0]             register_value,
   output logic [3:0]             debug_state
);

   typedef enum logic [3:0] {
      IDLE, ADDRESS, ADDRESS_ACK, REGISTER, REGISTER_ACK,
      WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d, ptr_inc;
   logic                   sda_low_q, sda_low_d;
   logic                   busy_q, busy_d;
   logic                   write_valid_q, write_valid_d;
   logic [INDEX_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   reg_we;
   logic [7:0]             regs_q [NUMBER_OF_REGISTERS];

   logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

   assign scl       = scl_sync_q[1];
   assign sda       = sda_sync_q[1];
   assign scl_rise  = scl & ~scl_prev_q;
   assign scl_fall  = ~scl & scl_prev_q;
   assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
   assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;
   assign ptr_inc   = ptr_q + 1'b1;

   assign external_serial_data   = sda_low_q ? 1'b0 : 1'bz;
   assign busy                   = busy_q;
   assign write_valid            = write_valid_q;
   assign write_register_address = wr_addr_q;
   assign write_data             = wr_data_q;
   assign register_value         = regs_q[register_index];
   assign debug_state            = state_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync_q    <= 2'b11;
         sda_sync_q    <= 2'b11;
         scl_prev_q    <= 1'b1;
         sda_prev_q    <= 1'b1;
         state_q       <= IDLE;
         bit_cnt_q     <= 4'd0;
         shift_q       <= 8'h00;
         ptr_q         <= '0;
         sda_low_q     <= 1'b0;
         busy_q        <= 1'b0;
         write_valid_q <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= 8'h00;
      end else begin
         scl_sync_q    <= {scl_sync_q[0], external_serial_clock};
         sda_sync_q    <= {sda_sync_q[0], external_serial_data};
         scl_prev_q    <= scl;
         sda_prev_q    <= sda;
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         ptr_q         <= ptr_d;
         sda_low_q     <= sda_low_d;
         busy_q        <= busy_d;
         write_valid_q <= write_valid_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regs_q[i] <= 8'h00;
      end else if (reg_we) begin
         regs_q[ptr_q] <= shift_q;
      end
   end

   // Bits are counted on SCL rise; every SDA drive change happens on SCL fall.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      ptr_d         = ptr_q;
      sda_low_d     = sda_low_q;
      busy_d        = busy_q;
      write_valid_d = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      reg_we        = 1'b0;
      if (stop_det) begin
         state_d   = IDLE;
         sda_low_d = 1'b0;
         busy_d    = 1'b0;
      end else if (start_det) begin
         state_d   = ADDRESS;
         bit_cnt_d = 4'd0;
         sda_low_d = 1'b0;
      end else begin
         case (state_q)
            ADDRESS, REGISTER, WRITE_DATA: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_low_d = 1'b1;
                  if (state_q == ADDRESS) begin
                     if (shift_q[7:1] == DEVICE_ADDRESS) begin
                        state_d = ADDRESS_ACK;
                        busy_d  = 1'b1;
                     end else begin
                        state_d   = IDLE;
                        sda_low_d = 1'b0;
                        busy_d    = 1'b0;
                     end
                  end else if (state_q == REGISTER) begin
                     state_d = REGISTER_ACK;
                     ptr_d   = shift_q[INDEX_WIDTH-1:0];
                  end else begin
                     state_d       = WRITE_ACK;
                     reg_we        = 1'b1;
                     write_valid_d = 1'b1;
                     wr_addr_d     = ptr_q;
                     wr_data_d     = shift_q;
                     ptr_d         = ptr_inc;
                  end
               end
            end
            ADDRESS_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  sda_low_d = 1'b0;
                  if (shift_q[0]) begin
                     state_d   = READ_DATA;
                     shift_d   = regs_q[ptr_q];
                     sda_low_d = ~regs_q[ptr_q][7];
                  end else begin
                     state_d = REGISTER;
                  end
               end
            end
            REGISTER_ACK, WRITE_ACK: begin
               if (scl_fall) begin
                  state_d   = WRITE_DATA;
                  bit_cnt_d = 4'd0;
                  sda_low_d = 1'b0;
               end
            end
            READ_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     state_d   = READ_ACK;
                     sda_low_d = 1'b0;
                  end else begin
                     shift_d   = {shift_q[6:0], 1'b0};
                     sda_low_d = ~shift_q[6];
                  end
               end
            end
            READ_ACK: begin
               // The master's acknowledge bit is parked in shift_q[0] until the fall.
               if (scl_rise) begin
                  shift_d[0] = sda;
               end else if (scl_fall) begin
                  if (shift_q[0]) begin
                     state_d = IDLE;
                  end else begin
                     state_d   = READ_DATA;
                     bit_cnt_d = 4'd0;
                     ptr_d     = ptr_inc;
                     shift_d   = regs_q[ptr_inc];
                     sda_low_d = ~regs_q[ptr_inc][7];
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule
